// File: rtl/mips31_pkg.sv
// mips31_pkg: fetch-stage state type and shared constants for the MIPS31 core
package mips31_pkg;
  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {S_RESET = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2} fetch_state_e;
endpackage

// File: rtl/pc_register.sv
// pc_register: program counter with redirect/sequential next-PC select and sticky misalign flag
module pc_register import mips31_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC = mips31_pkg::PC_INC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        seq_en,
  input  logic [31:0] seq_base,
  output logic [31:0] pc_d,
  output logic        misalign
);
  logic [31:0] pc_q;
  logic mis_q, mis_d;
  always_comb begin
    pc_d = redirect_en ? {redirect_pc[31:2], 2'b00} : seq_en ? seq_base + PC_INC : pc_q;
    mis_d = mis_q || (redirect_en && redirect_pc[1:0] != 2'b00);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      mis_q <= mis_d;
    end
  end
  assign misalign = mis_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: req/ack instruction fetch, instruction register and valid/ready hand-off to decode
module instruction_fetch_unit import mips31_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INC = mips31_pkg::PC_INC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction_code,
  output logic [31:0]        instr_pc,
  output logic [31:0]        instr_pc_plus4,
  output logic               fetch_misalign,
  output logic [31:0]        fetch_count
);
  fetch_state_e state_q, state_d;
  logic kill_q, kill_d, valid_q, valid_d, redir, seq_en;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [31:0] ipc_q, ipc_d, ipc4_q, ipc4_d, cnt_q, cnt_d, addr_q, addr_d, pc_d;
  assign redir = redirect_valid && state_q != S_RESET;
  assign seq_en = state_q == S_HOLD && instr_ready && !redir;
  pc_register #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) u_pc (
    .clk(clk),
    .rst_n(rst_n),
    .redirect_en(redir),
    .redirect_pc(redirect_pc),
    .seq_en(seq_en),
    .seq_base(ipc_q),
    .pc_d(pc_d),
    .misalign(fetch_misalign)
  );
  always_comb begin
    state_d = state_q;
    kill_d = kill_q;
    valid_d = valid_q;
    ir_d = ir_q;
    ipc_d = ipc_q;
    ipc4_d = ipc4_q;
    case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ: begin
        kill_d = imem_ack ? 1'b0 : kill_q || redir;
        if (imem_ack && !kill_q && !redir) begin
          ir_d = imem_rdata;
          ipc_d = addr_q;
          ipc4_d = addr_q + PC_INC;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: if (redir || instr_ready) begin
        valid_d = 1'b0;
        state_d = S_REQ;
      end
      default: state_d = S_RESET;
    endcase
  end
  // a new request address is latched only when a request is issued, so it stays stable until ack
  assign addr_d = (state_d == S_REQ && (state_q != S_REQ || imem_ack)) ? pc_d : addr_q;
  assign cnt_d = cnt_q + {31'd0, seq_en};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      kill_q <= 1'b0;
      valid_q <= 1'b0;
      ir_q <= '0;
      ipc_q <= '0;
      ipc4_q <= '0;
      cnt_q <= '0;
      addr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      kill_q <= kill_d;
      valid_q <= valid_d;
      ir_q <= ir_d;
      ipc_q <= ipc_d;
      ipc4_q <= ipc4_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
    end
  end
  assign imem_req = state_q == S_REQ;
  assign imem_addr = addr_q;
  assign instr_valid = valid_q;
  assign instruction_code = ir_q;
  assign instr_pc = ipc_q;
  assign instr_pc_plus4 = ipc4_q;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: table vectors, directed corner sequences and a randomized program-order model
module tb_instruction_fetch_unit;
  logic clk, rst_n, imem_req, imem_ack, redirect_valid, instr_valid, instr_ready, fetch_misalign;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction_code, instr_pc, instr_pc_plus4, fetch_count;
  logic use_rd;
  logic [31:0] rd;
  int n_cmp, n_bad;
  typedef struct {
    logic ack, rdy;
    logic [31:0] rd;
    logic e_req;
    logic [31:0] e_addr;
    logic e_val;
    logic [31:0] e_code, e_pc, e_cnt;
  } vec_t;
  vec_t tab[15];
  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction_code(instruction_code),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4), .fetch_misalign(fetch_misalign),
    .fetch_count(fetch_count)
  );
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction
  assign imem_rdata = use_rd ? rd : memf(imem_addr);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic ack, rdy, input logic [31:0] r, input logic er,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ec, ep, en);
    vec_t v;
    v.ack = ack; v.rdy = rdy; v.rd = r; v.e_req = er; v.e_addr = ea;
    v.e_val = ev; v.e_code = ec; v.e_pc = ep; v.e_cnt = en;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  initial begin
    logic [31:0] m_pc, m_cnt, pend_addr;
    logic m_mis, pend;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    use_rd = 1'b1; rd = '0;
    tab[0]  = mk(1, 1, 32'h1111_0000, 0, 32'h0,          0, 32'h0,          32'h0,          0);
    tab[1]  = mk(1, 1, 32'hA000_0001, 1, 32'h0040_0000, 0, 32'h0,          32'h0,          0);
    tab[2]  = mk(1, 1, 32'h0BAD_0BAD, 0, 32'h0,          1, 32'hA000_0001, 32'h0040_0000, 0);
    tab[3]  = mk(1, 1, 32'hA000_0002, 1, 32'h0040_0004, 0, 32'h0,          32'h0,          1);
    tab[4]  = mk(1, 1, 32'h0BAD_0BAD, 0, 32'h0,          1, 32'hA000_0002, 32'h0040_0004, 1);
    tab[5]  = mk(1, 1, 32'hA000_0003, 1, 32'h0040_0008, 0, 32'h0,          32'h0,          2);
    tab[6]  = mk(1, 1, 32'h0BAD_0BAD, 0, 32'h0,          1, 32'hA000_0003, 32'h0040_0008, 2);
    tab[7]  = mk(1, 0, 32'h2008_0005, 1, 32'h0040_000C, 0, 32'h0,          32'h0,          3);
    for (int i = 8; i < 13; i++)
      tab[i] = mk(1, 0, 32'hDEAD_BEEF, 0, 32'h0, 1, 32'h2008_0005, 32'h0040_000C, 3);
    tab[13] = mk(1, 1, 32'hDEAD_BEEF, 0, 32'h0,          1, 32'h2008_0005, 32'h0040_000C, 3);
    tab[14] = mk(0, 1, 32'h0,         1, 32'h0040_0010, 0, 32'h0,          32'h0,          4);
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_code", instruction_code, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_pc4", instr_pc_plus4, 0);
    chk("rst_mis", fetch_misalign, 0);
    chk("rst_cnt", fetch_count, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("t%0d_req", i), imem_req, tab[i].e_req);
      chk($sformatf("t%0d_valid", i), instr_valid, tab[i].e_val);
      chk($sformatf("t%0d_cnt", i), fetch_count, tab[i].e_cnt);
      if (tab[i].e_req) chk($sformatf("t%0d_addr", i), imem_addr, tab[i].e_addr);
      if (tab[i].e_val) begin
        chk($sformatf("t%0d_code", i), instruction_code, tab[i].e_code);
        chk($sformatf("t%0d_ipc", i), instr_pc, tab[i].e_pc);
        chk($sformatf("t%0d_pc4", i), instr_pc_plus4, tab[i].e_pc + 32'd4);
      end
      imem_ack = tab[i].ack; instr_ready = tab[i].rdy; rd = tab[i].rd;
      @(negedge clk);
    end
    // redirect in S_REQ with ack delayed: in-flight word must be discarded
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("kill_addr_hold", imem_addr, 32'h0040_0010);
    chk("kill_req_hold", imem_req, 1);
    repeat (2) @(negedge clk);
    chk("kill_addr_hold2", imem_addr, 32'h0040_0010);
    imem_ack = 1'b1; rd = 32'h1111_1111;
    @(negedge clk);
    chk("kill_discard", instr_valid, 0);
    chk("kill_newaddr", imem_addr, 32'h0040_0100);
    chk("kill_req", imem_req, 1);
    rd = 32'h2222_2222; instr_ready = 1'b0;
    @(negedge clk);
    chk("tgt_valid", instr_valid, 1);
    chk("tgt_code", instruction_code, 32'h2222_2222);
    chk("tgt_pc", instr_pc, 32'h0040_0100);
    chk("tgt_pc4", instr_pc_plus4, 32'h0040_0104);
    chk("tgt_cnt", fetch_count, 4);
    // redirect in S_HOLD together with instr_ready: not counted
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0200; instr_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0; instr_ready = 1'b0;
    chk("hold_redir_cnt", fetch_count, 4);
    chk("hold_redir_valid", instr_valid, 0);
    chk("hold_redir_addr", imem_addr, 32'h0040_0200);
    // redirect and ack in the same cycle
    imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0300; rd = 32'h3333_3333;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("same_valid", instr_valid, 0);
    chk("same_addr", imem_addr, 32'h0040_0300);
    chk("same_mis", fetch_misalign, 0);
    rd = 32'h4444_4444;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("same_tgt_code", instruction_code, 32'h4444_4444);
    chk("same_tgt_pc", instr_pc, 32'h0040_0300);
    // misaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("mis_addr", imem_addr, 32'h0040_0100);
    chk("mis_flag", fetch_misalign, 1);
    chk("mis_cnt", fetch_count, 4);
    // wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0; imem_ack = 1'b1;
    @(negedge clk);
    chk("wrap_tgt_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_tgt_valid", instr_valid, 0);
    instr_ready = 1'b1; rd = 32'h5555_5555;
    @(negedge clk);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", instr_pc_plus4, 32'h0);
    chk("wrap_code", instruction_code, 32'h5555_5555);
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_cnt", fetch_count, 5);
    chk("mis_sticky", fetch_misalign, 1);
    // asynchronous reset mid S_HOLD
    instr_ready = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("pre_arst_valid", instr_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_req", imem_req, 0);
    chk("arst_cnt", fetch_count, 0);
    chk("arst_mis", fetch_misalign, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_idle_req", imem_req, 0);
    @(negedge clk);
    chk("rel_req", imem_req, 1);
    chk("rel_addr", imem_addr, 32'h0040_0000);
    // randomized phase against a program-order model
    use_rd = 1'b0;
    m_pc = 32'h0040_0000; m_cnt = 0; m_mis = 1'b0; pend = 1'b0; pend_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      chk("r_cnt", fetch_count, m_cnt);
      chk("r_mis", {31'd0, fetch_misalign}, {31'd0, m_mis});
      if (instr_valid) begin
        chk("r_ipc", instr_pc, m_pc);
        chk("r_code", instruction_code, memf(m_pc));
        chk("r_pc4", instr_pc_plus4, m_pc + 32'd4);
      end
      if (pend) begin
        chk("r_req_hold", {31'd0, imem_req}, 1);
        chk("r_addr_hold", imem_addr, pend_addr);
      end
      imem_ack = ($urandom % 3) != 0;
      instr_ready = $urandom % 2;
      redirect_valid = ($urandom % 8) == 0;
      redirect_pc = ($urandom % 6 == 0) ? $urandom : 32'h0040_0000 + (($urandom % 64) << 2);
      if (redirect_valid) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        m_mis = m_mis | (redirect_pc[1:0] != 2'b00);
      end else if (instr_valid && instr_ready) begin
        m_pc = m_pc + 32'd4;
        m_cnt = m_cnt + 1;
      end
      pend = imem_req && !imem_ack;
      pend_addr = imem_addr;
      @(negedge clk);
    end
    chk("r_progress", {31'd0, m_cnt > 200}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
